sram_1r1w_masked_init: RTL and testbench

- Parametrised single-clock 1-read/1-write SRAM behavioural model for the formal/demo RTL tree.
- Successor to the fixed 512x74 unmasked array model.
- Adds per-segment write mask, selectable read latency, read-during-write bypass, defined hold-on-idle read data, and a post-reset zero-fill sweep.
- Sits under cache/queue wrappers that need deterministic contents after reset, for formal equivalence and fuzz replay.

---
 rtl/sram_pkg.sv | 29 ++
 rtl/sram_1r1w_masked_init_if.sv | 30 +++
 rtl/sram_rd_pipe.sv | 54 +++++
 rtl/sram_1r1w_masked_init.sv | 116 +++++++++++
 tb/tb_sram_1r1w_masked_init.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and mask helpers for the 1R1W masked SRAM
package sram_pkg;

  // Sweep FSM: zero-fill after reset, then normal operation
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  // Upper bound on entry width handled by the mask expander
  localparam int MAX_W = 1024;

  // Number of write-mask segments in one entry
  function automatic int mask_segs(input int width, input int gran);
    return width / gran;
  endfunction

  // Expand a per-segment mask into a per-bit mask (segment i covers bits [i*gran +: gran])
  function automatic logic [MAX_W-1:0] expand_mask(input logic [MAX_W-1:0] seg_mask,
                                                   input int gran);
    logic [MAX_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_W; i++) begin
      bits[10'(i)] = seg_mask[10'(i / gran)];
    end
    return bits;
  endfunction

endpackage

// File: rtl/sram_1r1w_masked_init_if.sv
// rtl/sram_1r1w_masked_init_if.sv - read/write port bundle for the 1R1W masked SRAM
interface sram_1r1w_masked_init_if #(
  parameter int ADDR_W = 9,
  parameter int WIDTH  = 74,
  parameter int MASK_W = 1
);

  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [WIDTH-1:0]  R0_data;
  logic              R0_valid;

  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [WIDTH-1:0]  W0_data;
  logic [MASK_W-1:0] W0_mask;

  // Requester side: issues reads and writes, receives read data
  modport master (
    output R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    input  R0_data, R0_valid
  );

  // Memory side
  modport slave (
    input  R0_en, R0_addr, W0_en, W0_addr, W0_data, W0_mask,
    output R0_data, R0_valid
  );

endinterface

// File: rtl/sram_rd_pipe.sv
// rtl/sram_rd_pipe.sv - 1 or 2 cycle read output stage with hold-last-value data
module sram_rd_pipe #(
  parameter int WIDTH        = 74,
  parameter int READ_LATENCY = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  // First stage: capture read result; data only moves when a result arrives
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    // Output register stage; holds last result while idle
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
  end else begin : g_lat1
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end

endmodule

// File: rtl/sram_1r1w_masked_init.sv
// rtl/sram_1r1w_masked_init.sv - 1R1W SRAM model with segment mask, bypass and zero-fill
module sram_1r1w_masked_init
  import sram_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int WIDTH        = 74,
  parameter int MASK_GRAN    = 74,
  parameter int ADDR_W       = 9,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  output logic                   init_done,
  sram_1r1w_masked_init_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject parameter sets the array cannot represent
  if (mask_segs(WIDTH, MASK_GRAN) * MASK_GRAN != WIDTH) begin : g_bad_gran
    $fatal(1, "sram_1r1w_masked_init: WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "sram_1r1w_masked_init: READ_LATENCY must be 1 or 2");
  end
  if ((1 << ADDR_W) < DEPTH) begin : g_bad_addr
    $fatal(1, "sram_1r1w_masked_init: ADDR_W too small for DEPTH");
  end

  logic [WIDTH-1:0] ram [0:DEPTH-1];

  sram_state_e      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             sweep_we;

  logic             rd_in_range, wr_in_range;
  logic             rd_fire, wr_fire, collide;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [WIDTH-1:0] wbm, old_data, merged, rd_result;

  // Sweep FSM state register; reset restarts the fill from entry 0
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep FSM next state: walk every entry once, then park in READY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  // Sweep FSM outputs
  always_comb begin
    sweep_we  = (state_q == ST_INIT);
    init_done = (state_q == ST_READY);
  end

  // Request decode: user traffic only counts once the array is initialised
  always_comb begin
    rd_in_range = ({{(32-ADDR_W){1'b0}}, bus.R0_addr} < 32'(DEPTH));
    wr_in_range = ({{(32-ADDR_W){1'b0}}, bus.W0_addr} < 32'(DEPTH));
    r_idx       = bus.R0_addr[IDX_W-1:0];
    w_idx       = bus.W0_addr[IDX_W-1:0];
    rd_fire     = reset_n && init_done && bus.R0_en;
    wr_fire     = reset_n && init_done && bus.W0_en && wr_in_range;
    collide     = rd_fire && wr_fire && (bus.R0_addr == bus.W0_addr);
    wbm         = WIDTH'(expand_mask(MAX_W'(bus.W0_mask), MASK_GRAN));
  end

  // Read data path: old contents, optionally overlaid with the colliding write
  always_comb begin
    old_data  = rd_in_range ? ram[r_idx] : '0;
    merged    = (old_data & ~wbm) | (bus.W0_data & wbm);
    rd_result = ((BYPASS != 0) && collide) ? merged : old_data;
  end

  // Array update: zero-fill during sweep, masked merge in normal operation
  always_ff @(posedge clock) begin
    if (reset_n && sweep_we) begin
      ram[cnt_q] <= '0;
    end else if (wr_fire) begin
      ram[w_idx] <= (ram[w_idx] & ~wbm) | (bus.W0_data & wbm);
    end
  end

  sram_rd_pipe #(
    .WIDTH       (WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (rd_fire),
    .in_data  (rd_result),
    .out_valid(bus.R0_valid),
    .out_data (bus.R0_data)
  );

endmodule

// File: tb/tb_sram_1r1w_masked_init.sv
// tb/tb_sram_1r1w_masked_init.sv - scoreboard bench for two SRAM configurations
module tb_sram_1r1w_masked_init;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic ra_n, rb_n;
  logic a_done, b_done;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   k;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t e_a, e_b;

  sram_1r1w_masked_init_if #(.ADDR_W(4), .WIDTH(16), .MASK_W(2)) ia ();
  sram_1r1w_masked_init_if #(.ADDR_W(5), .WIDTH(16), .MASK_W(2)) ib ();

  // A: 8 deep, latency 1, write-first collisions
  sram_1r1w_masked_init #(
    .DEPTH(8), .WIDTH(16), .MASK_GRAN(8), .ADDR_W(4), .READ_LATENCY(1), .BYPASS(1)
  ) u_a (
    .clock(clock), .reset_n(ra_n), .init_done(a_done), .bus(ia)
  );

  // B: 16 deep, latency 2, read-first collisions
  sram_1r1w_masked_init #(
    .DEPTH(16), .WIDTH(16), .MASK_GRAN(8), .ADDR_W(5), .READ_LATENCY(2), .BYPASS(0)
  ) u_b (
    .clock(clock), .reset_n(rb_n), .init_done(b_done), .bus(ib)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    ia.W0_en = 1'b1; ia.W0_addr = a; ia.W0_data = d; ia.W0_mask = m;
    tick();
    ia.W0_en = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [15:0] d);
    ia.R0_en = 1'b1; ia.R0_addr = a;
    qa.push_back('{data: d, due: cyc + 1});
    tick();
    ia.R0_en = 1'b0;
  endtask

  task automatic col_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m,
                       input logic [15:0] x);
    ia.W0_en = 1'b1; ia.W0_addr = a; ia.W0_data = d; ia.W0_mask = m;
    ia.R0_en = 1'b1; ia.R0_addr = a;
    qa.push_back('{data: x, due: cyc + 1});
    tick();
    ia.W0_en = 1'b0; ia.R0_en = 1'b0;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [15:0] d, input logic [1:0] m);
    ib.W0_en = 1'b1; ib.W0_addr = a; ib.W0_data = d; ib.W0_mask = m;
    tick();
    ib.W0_en = 1'b0;
  endtask

  task automatic rd_b(input logic [4:0] a, input logic [15:0] d);
    ib.R0_en = 1'b1; ib.R0_addr = a;
    qb.push_back('{data: d, due: cyc + 2});
    tick();
    ib.R0_en = 1'b0;
  endtask

  // Monitor: every presented result is matched against the oldest expected one
  always @(negedge clock) begin
    if (ia.R0_valid) begin
      if (qa.size() == 0) begin
        check("a_unexpected_valid", 32'(ia.R0_valid), 32'd0);
      end else begin
        e_a = qa.pop_front();
        check("a_rd_data", 32'(ia.R0_data), 32'(e_a.data));
        check("a_rd_cycle", cyc, e_a.due);
      end
    end else if (qa.size() != 0 && qa[0].due <= cyc) begin
      check("a_missing_valid", 32'(ia.R0_valid), 32'd1);
      void'(qa.pop_front());
    end

    if (ib.R0_valid) begin
      if (qb.size() == 0) begin
        check("b_unexpected_valid", 32'(ib.R0_valid), 32'd0);
      end else begin
        e_b = qb.pop_front();
        check("b_rd_data", 32'(ib.R0_data), 32'(e_b.data));
        check("b_rd_cycle", cyc, e_b.due);
      end
    end else if (qb.size() != 0 && qb[0].due <= cyc) begin
      check("b_missing_valid", 32'(ib.R0_valid), 32'd1);
      void'(qb.pop_front());
    end
  end

  initial begin
    ra_n = 1'b0; rb_n = 1'b0;
    ia.R0_en = 1'b0; ia.R0_addr = '0; ia.W0_en = 1'b0; ia.W0_addr = '0;
    ia.W0_data = '0; ia.W0_mask = '0;
    ib.R0_en = 1'b0; ib.R0_addr = '0; ib.W0_en = 1'b0; ib.W0_addr = '0;
    ib.W0_data = '0; ib.W0_mask = '0;
    repeat (3) tick();

    check("a_reset_done", 32'(a_done), 32'd0);
    check("a_reset_valid", 32'(ia.R0_valid), 32'd0);
    check("a_reset_data", 32'(ia.R0_data), 32'd0);
    check("b_reset_done", 32'(b_done), 32'd0);
    check("b_reset_valid", 32'(ib.R0_valid), 32'd0);
    check("b_reset_data", 32'(ib.R0_data), 32'd0);

    // A: zero-fill with user traffic during the sweep that must be dropped
    ra_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 50; i++) begin
      if (i <= 5) begin
        ia.W0_en = 1'b1; ia.W0_addr = 4'd3; ia.W0_data = 16'h03FF; ia.W0_mask = 2'b11;
        ia.R0_en = 1'b1; ia.R0_addr = 4'd3;
      end else begin
        ia.W0_en = 1'b0; ia.R0_en = 1'b0;
      end
      tick();
      check("a_sweep_valid", 32'(ia.R0_valid), 32'd0);
      check("a_sweep_data", 32'(ia.R0_data), 32'd0);
      if (a_done) begin
        k = i;
        break;
      end
    end
    ia.W0_en = 1'b0; ia.R0_en = 1'b0;
    check("a_init_cycles", k, 8);

    for (int i = 0; i < 8; i++) rd_a(4'(i), 16'h0000);

    wr_a(4'd5, 16'hABCD, 2'b11);
    wr_a(4'd5, 16'h1234, 2'b01);
    rd_a(4'd5, 16'hAB34);
    wr_a(4'd5, 16'hFFFF, 2'b00);
    rd_a(4'd5, 16'hAB34);
    wr_a(4'd9, 16'hFFFF, 2'b11);
    rd_a(4'd9, 16'h0000);
    rd_a(4'd1, 16'h0000);
    wr_a(4'd2, 16'h1111, 2'b11);
    col_a(4'd2, 16'h2222, 2'b11, 16'h2222);
    rd_a(4'd2, 16'h2222);
    col_a(4'd2, 16'h55AA, 2'b01, 16'h22AA);
    rd_a(4'd2, 16'h22AA);
    tick(); tick();
    check("a_hold_valid", 32'(ia.R0_valid), 32'd0);
    check("a_hold_data", 32'(ia.R0_data), 32'h22AA);

    // B: reset pulsed in the middle of the sweep, reads asserted throughout
    ib.R0_en = 1'b1; ib.R0_addr = 5'd0;
    ib.W0_en = 1'b1; ib.W0_addr = 5'd3; ib.W0_data = 16'h03FF; ib.W0_mask = 2'b11;
    rb_n = 1'b1;
    repeat (7) begin
      tick();
      check("b_sweep1_done", 32'(b_done), 32'd0);
    end
    rb_n = 1'b0;
    tick();
    rb_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      check("b_sweep2_valid", 32'(ib.R0_valid), 32'd0);
      if (b_done) begin
        k = i;
        break;
      end
    end
    ib.R0_en = 1'b0; ib.W0_en = 1'b0;
    check("b_init_cycles", k, 16);

    rd_b(5'd3, 16'h0000);
    rd_b(5'd15, 16'h0000);
    wr_b(5'd0, 16'h0A0A, 2'b11);
    wr_b(5'd1, 16'h1B1B, 2'b11);
    wr_b(5'd2, 16'h1111, 2'b11);
    rd_b(5'd0, 16'h0A0A);
    rd_b(5'd1, 16'h1B1B);
    rd_b(5'd2, 16'h1111);
    tick(); tick(); tick();
    check("b_hold_valid", 32'(ib.R0_valid), 32'd0);
    check("b_hold_data", 32'(ib.R0_data), 32'h1111);

    ib.W0_en = 1'b1; ib.W0_addr = 5'd2; ib.W0_data = 16'h2222; ib.W0_mask = 2'b11;
    ib.R0_en = 1'b1; ib.R0_addr = 5'd2;
    qb.push_back('{data: 16'h1111, due: cyc + 2});
    tick();
    ib.W0_en = 1'b0; ib.R0_en = 1'b0;
    rd_b(5'd2, 16'h2222);
    wr_b(5'd20, 16'hBEEF, 2'b11);
    rd_b(5'd20, 16'h0000);
    rd_b(5'd4, 16'h0000);

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      tick();
    end
    check("a_queue_drained", 32'(qa.size()), 32'd0);
    check("b_queue_drained", 32'(qb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
